// File: rtl/ddbb128_cfg_pkg.sv
// Shared definitions for the 128-bit ddbb config bus: row map, lane offsets,
// enumerator state type and the registered request payload.
package ddbb128_cfg_pkg;

  localparam int unsigned DAT_W    = 128;
  localparam int unsigned ADR_W    = 32;
  localparam int unsigned SEL_W    = 16;
  localparam int unsigned ROW_W    = 5;
  localparam int unsigned DEV_W    = 5;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned IRQ_W    = 5;
  localparam int unsigned BAR_W    = 32;
  localparam int unsigned NUM_BARS = 3;
  localparam int unsigned IDX_W    = 2;

  localparam logic [ROW_W-1:0] ROW_ID  = 5'd0;
  localparam logic [ROW_W-1:0] ROW_BAR = 5'd1;
  localparam logic [ROW_W-1:0] ROW_IRQ = 5'd3;

  // Bit offsets of fields inside a 128-bit row
  localparam int unsigned VENDOR_LSB = 0;
  localparam int unsigned CMD_LSB    = 64;
  localparam int unsigned IRQ_LSB    = 96;
  localparam int unsigned BARS_W     = NUM_BARS * BAR_W;

  localparam logic [15:0] VENDOR_NONE = 16'hFFFF;
  localparam logic [15:0] CMD_ENABLE  = 16'h0006;
  localparam logic [IRQ_W-1:0] IRQ_MAX = 5'd31;

  localparam logic [SEL_W-1:0] SEL_RD  = 16'hFFFF;
  localparam logic [SEL_W-1:0] SEL_BAR = 16'h0FFF;
  localparam logic [SEL_W-1:0] SEL_IRQ = 16'h1000;
  localparam logic [SEL_W-1:0] SEL_CMD = 16'h0300;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_WAIT_ID,
    ST_SZ_WR,
    ST_SZ_RD,
    ST_SZ_WAIT,
    ST_CALC,
    ST_BAR_WR,
    ST_IRQ_WR,
    ST_CMD_WR,
    ST_NEXT,
    ST_DONE
  } enum_state_e;

  typedef struct packed {
    logic             cs;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } cfg_req_t;

  // Config address of function 0 of a device on a bus
  function automatic logic [ADR_W-1:0] cfg_adr(input logic [7:0] bus,
                                               input logic [DEV_W-1:0] dev,
                                               input logic [ROW_W-1:0] row);
    return {4'h0, bus, dev, 3'd0, 3'd0, row, 4'h0};
  endfunction

endpackage

// File: rtl/ddbb128_config_enum_if.sv
// Config bus between the enumerator (master) and the responder mux (slave).
interface ddbb128_config_enum_if;
  import ddbb128_cfg_pkg::*;

  logic             cs_config_o;
  logic             we_o;
  logic [SEL_W-1:0] sel_o;
  logic [ADR_W-1:0] adr_o;
  logic [DAT_W-1:0] dat_o;
  logic [DAT_W-1:0] dat_i;

  modport master (
    output cs_config_o, we_o, sel_o, adr_o, dat_o,
    input  dat_i
  );

  modport slave (
    input  cs_config_o, we_o, sel_o, adr_o, dat_o,
    output dat_i
  );

endinterface

// File: rtl/ddbb128_bar_alloc.sv
// Naturally aligned BAR placement: base, following free address and window
// overflow for one BAR size mask against the current allocation pointer.
module ddbb128_bar_alloc
  import ddbb128_cfg_pkg::*;
(
  input  logic [BAR_W:0]   next_i,
  input  logic [BAR_W-1:0] mask_i,
  input  logic [BAR_W-1:0] limit_i,
  output logic [BAR_W-1:0] base_c,
  output logic [BAR_W:0]   next_c,
  output logic             ovf_c
);

  logic [BAR_W:0] size_m1;
  logic [BAR_W:0] sum;
  logic [BAR_W:0] end_a;

  // Round up to the BAR size, then span size-1 bytes; a carry out of bit 31
  // at either step means the BAR does not fit in the address space at all.
  always_comb begin
    size_m1 = {1'b0, ~mask_i};
    sum     = next_i + size_m1;
    base_c  = sum[BAR_W-1:0] & mask_i;
    end_a   = {1'b0, base_c} + size_m1;
    ovf_c   = sum[BAR_W] | end_a[BAR_W] | (end_a[BAR_W-1:0] > limit_i);
    next_c  = end_a + (BAR_W+1)'(1);
  end

endmodule

// File: rtl/ddbb128_config_enum.sv
// Config-space enumerator: scans one bus, sizes and places BAR0-2 of each
// present function 0, hands out IRQ lines and enables decode/mastering.
module ddbb128_config_enum
  import ddbb128_cfg_pkg::*;
#(
  parameter logic [7:0]       BUS_NUM   = 8'd0,
  parameter logic [CNT_W-1:0] MAX_DEV   = 6'd32,
  parameter logic [BAR_W-1:0] MEM_BASE  = 32'hD0000000,
  parameter logic [BAR_W-1:0] MEM_LIMIT = 32'hDFFFFFFF,
  parameter logic [IRQ_W-1:0] IRQ_BASE  = 5'd1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     dev_count_o,
  ddbb128_config_enum_if.master cfg
);

  enum_state_e                     state_q, state_d;
  logic [CNT_W-1:0]                dev_q, dev_d;
  logic [BAR_W:0]                  next_q, next_d;
  logic [IRQ_W-1:0]                irq_q, irq_d;
  logic [NUM_BARS-1:0][BAR_W-1:0]  mask_q, mask_d;
  logic [NUM_BARS-1:0][BAR_W-1:0]  base_q, base_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [CNT_W-1:0]                cnt_d;
  logic                            err_d;
  cfg_req_t                        req_d;

  logic [BAR_W-1:0] cur_mask;
  logic [BAR_W-1:0] alloc_base;
  logic [BAR_W:0]   alloc_next;
  logic             alloc_ovf;

  // Upper read lanes carry nothing the enumerator consumes
  logic unused_dat_hi;
  assign unused_dat_hi = ^cfg.dat_i[DAT_W-1:BARS_W];

  assign cur_mask = mask_q[idx_q];

  ddbb128_bar_alloc u_alloc (
    .next_i  (next_q),
    .mask_i  (cur_mask),
    .limit_i (MEM_LIMIT),
    .base_c  (alloc_base),
    .next_c  (alloc_next),
    .ovf_c   (alloc_ovf)
  );

  // Next-state, datapath updates and bus request for the state being entered
  always_comb begin
    state_d = state_q;
    dev_d   = dev_q;
    next_d  = next_q;
    irq_d   = irq_q;
    mask_d  = mask_q;
    base_d  = base_q;
    idx_d   = idx_q;
    cnt_d   = dev_count_o;
    err_d   = err_o;
    req_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RD_ID;
          dev_d   = '0;
          next_d  = {1'b0, MEM_BASE};
          irq_d   = IRQ_BASE;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_RD_ID:   state_d = ST_WAIT_ID;
      ST_WAIT_ID: begin
        if (cfg.dat_i[VENDOR_LSB +: 16] == VENDOR_NONE) state_d = ST_NEXT;
        else                                            state_d = ST_SZ_WR;
      end
      ST_SZ_WR:   state_d = ST_SZ_RD;
      ST_SZ_RD:   state_d = ST_SZ_WAIT;
      ST_SZ_WAIT: begin
        mask_d  = cfg.dat_i[BARS_W-1:0];
        idx_d   = '0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        // One BAR per cycle; a BAR that does not fit is parked at 0
        if (cur_mask == '0) begin
          base_d[idx_q] = '0;
        end else if (alloc_ovf) begin
          base_d[idx_q] = '0;
          err_d         = 1'b1;
        end else begin
          base_d[idx_q] = alloc_base;
          next_d        = alloc_next;
        end
        idx_d = IDX_W'(idx_q + IDX_W'(1));
        if (idx_q == IDX_W'(NUM_BARS - 1)) state_d = ST_BAR_WR;
      end
      ST_BAR_WR:  state_d = ST_IRQ_WR;
      ST_IRQ_WR:  state_d = ST_CMD_WR;
      ST_CMD_WR: begin
        cnt_d   = CNT_W'(dev_count_o + CNT_W'(1));
        irq_d   = (irq_q == IRQ_MAX) ? IRQ_W'(1) : IRQ_W'(irq_q + IRQ_W'(1));
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        dev_d = CNT_W'(dev_q + CNT_W'(1));
        if (CNT_W'(dev_q + CNT_W'(1)) == MAX_DEV) state_d = ST_DONE;
        else                                      state_d = ST_RD_ID;
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_RD_ID: begin
        req_d.cs  = 1'b1;
        req_d.sel = SEL_RD;
        req_d.adr = cfg_adr(BUS_NUM, dev_d[DEV_W-1:0], ROW_ID);
      end
      ST_SZ_WR: begin
        req_d.cs               = 1'b1;
        req_d.we               = 1'b1;
        req_d.sel              = SEL_BAR;
        req_d.adr              = cfg_adr(BUS_NUM, dev_d[DEV_W-1:0], ROW_BAR);
        req_d.dat[BARS_W-1:0]  = '1;
      end
      ST_SZ_RD: begin
        req_d.cs  = 1'b1;
        req_d.sel = SEL_RD;
        req_d.adr = cfg_adr(BUS_NUM, dev_d[DEV_W-1:0], ROW_BAR);
      end
      ST_BAR_WR: begin
        req_d.cs               = 1'b1;
        req_d.we               = 1'b1;
        req_d.sel              = SEL_BAR;
        req_d.adr              = cfg_adr(BUS_NUM, dev_d[DEV_W-1:0], ROW_BAR);
        req_d.dat[BARS_W-1:0]  = base_d;
      end
      ST_IRQ_WR: begin
        req_d.cs                 = 1'b1;
        req_d.we                 = 1'b1;
        req_d.sel                = SEL_IRQ;
        req_d.adr                = cfg_adr(BUS_NUM, dev_d[DEV_W-1:0], ROW_IRQ);
        req_d.dat[IRQ_LSB +: 8]  = 8'(irq_d);
      end
      ST_CMD_WR: begin
        req_d.cs                 = 1'b1;
        req_d.we                 = 1'b1;
        req_d.sel                = SEL_CMD;
        req_d.adr                = cfg_adr(BUS_NUM, dev_d[DEV_W-1:0], ROW_ID);
        req_d.dat[CMD_LSB +: 16] = CMD_ENABLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      dev_q           <= '0;
      next_q          <= {1'b0, MEM_BASE};
      irq_q           <= IRQ_BASE;
      mask_q          <= '0;
      base_q          <= '0;
      idx_q           <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      dev_count_o     <= '0;
      cfg.cs_config_o <= 1'b0;
      cfg.we_o        <= 1'b0;
      cfg.sel_o       <= '0;
      cfg.adr_o       <= '0;
      cfg.dat_o       <= '0;
    end else begin
      state_q         <= state_d;
      dev_q           <= dev_d;
      next_q          <= next_d;
      irq_q           <= irq_d;
      mask_q          <= mask_d;
      base_q          <= base_d;
      idx_q           <= idx_d;
      busy_o          <= (state_d != ST_IDLE);
      done_o          <= (state_d == ST_DONE);
      err_o           <= err_d;
      dev_count_o     <= cnt_d;
      cfg.cs_config_o <= req_d.cs;
      cfg.we_o        <= req_d.we;
      cfg.sel_o       <= req_d.sel;
      cfg.adr_o       <= req_d.adr;
      cfg.dat_o       <= req_d.dat;
    end
  end

endmodule

// File: tb/tb_ddbb128_config_enum.sv
// Bench for ddbb128_config_enum: responder model on the bus, expected strobes
// queued per scan and checked by an independent monitor thread.
module tb_ddbb128_config_enum;
  import ddbb128_cfg_pkg::*;

  localparam logic [7:0] BUS = 8'h03;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [5:0] dev_count_o;

  always #5 clk = ~clk;

  ddbb128_config_enum_if bus ();

  ddbb128_config_enum #(
    .BUS_NUM   (BUS),
    .MAX_DEV   (6'd4),
    .MEM_BASE  (32'hD0000000),
    .MEM_LIMIT (32'hDFFFFFFF),
    .IRQ_BASE  (5'd31)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .dev_count_o (dev_count_o),
    .cfg         (bus)
  );

  typedef struct packed {
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
  } txn_t;

  txn_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic        present [4];
  logic [31:0] dm0 [4];
  logic [31:0] dm1 [4];
  logic [31:0] dm2 [4];

  function automatic logic [127:0] resp(input logic [31:0] a);
    int d;
    d = int'(a[19:15]);
    if (d > 3 || !present[d]) return '1;
    if (a[8:4] == 5'd0) return {96'h0, 16'h5A01, 16'h1AB5};
    if (a[8:4] == 5'd1) return {32'h0, dm2[d], dm1[d], dm0[d]};
    return '0;
  endfunction

  // Responder: data for a read strobe appears one cycle later, else all-ones
  logic [127:0] pend = '1;
  always @(negedge clk) begin
    bus.dat_i = pend;
    pend = '1;
    if (bus.cs_config_o && !bus.we_o) pend = resp(bus.adr_o);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_adr(input int d, input logic [4:0] row);
    return {4'h0, BUS, 5'(d), 6'd0, row, 4'h0};
  endfunction

  task automatic push_rd(input int d, input logic [4:0] row);
    txn_t t;
    t.we = 1'b0; t.sel = '0; t.adr = exp_adr(d, row); t.dat = '0;
    exp_q.push_back(t);
  endtask

  task automatic push_wr(input int d, input logic [4:0] row, input logic [15:0] sel,
                         input logic [127:0] dat);
    txn_t t;
    t.we = 1'b1; t.sel = sel; t.adr = exp_adr(d, row); t.dat = dat;
    exp_q.push_back(t);
  endtask

  task automatic push_present(input int d, input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic [4:0] irq);
    push_rd(d, 5'd0);
    push_wr(d, 5'd1, 16'h0FFF, {32'h0, {96{1'b1}}});
    push_rd(d, 5'd1);
    push_wr(d, 5'd1, 16'h0FFF, {32'h0, b2, b1, b0});
    push_wr(d, 5'd3, 16'h1000, {24'h0, 3'b000, irq, 96'h0});
    push_wr(d, 5'd0, 16'h0300, {48'h0, 16'h0006, 64'h0});
  endtask

  task automatic clear_devs();
    for (int i = 0; i < 4; i++) begin
      present[i] = 1'b0; dm0[i] = '0; dm1[i] = '0; dm2[i] = '0;
    end
  endtask

  task automatic set_dev(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
    present[d] = 1'b1; dm0[d] = a; dm1[d] = b; dm2[d] = c;
  endtask

  // Monitor: every strobe must match the head of the expected queue
  task automatic mon_loop();
    txn_t t;
    logic prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cs_config_o === 1'b1) begin
        if (!bus.we_o) chk("read_spacing", 128'(prev_rd), 128'(0));
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: adr %h we %b, none queued", bus.adr_o, bus.we_o);
        end else begin
          t = exp_q.pop_front();
          chk("strobe_we", 128'(bus.we_o), 128'(t.we));
          chk("strobe_adr", 128'(bus.adr_o), 128'(t.adr));
          if (t.we) begin
            chk("wr_sel", 128'(bus.sel_o), 128'(t.sel));
            chk("wr_dat", bus.dat_o, t.dat);
          end
        end
      end
      prev_rd = (bus.cs_config_o === 1'b1) && (bus.we_o === 1'b0);
    end
  endtask

  // Called at a negedge; start is pulsed in cycle 0, done expected in cycle exp_cyc
  task automatic run_scan(input string nm, input int exp_cyc, input int exp_cnt,
                          input logic exp_err, input int restart_at);
    int   n = 0;
    logic gap = 1'b0;
    start_i = 1'b1;
    do begin
      @(negedge clk);
      n++;
      start_i = (n == restart_at);
      if (n == 1) begin
        chk({nm, "_start_busy"}, 128'(busy_o), 128'(1));
        chk({nm, "_start_err_clr"}, 128'(err_o), 128'(0));
        chk({nm, "_start_cnt_clr"}, 128'(dev_count_o), 128'(0));
      end
      if (!done_o && !busy_o) gap = 1'b1;
    end while (!done_o && n < 400);
    start_i = 1'b0;
    chk({nm, "_cycles"}, 128'(n), 128'(exp_cyc));
    chk({nm, "_busy_at_done"}, 128'(busy_o), 128'(1));
    chk({nm, "_busy_gap"}, 128'(gap), 128'(0));
    chk({nm, "_dev_count"}, 128'(dev_count_o), 128'(exp_cnt));
    chk({nm, "_err"}, 128'(err_o), 128'(exp_err));
    @(negedge clk);
    chk({nm, "_after_done"}, 128'({busy_o, done_o}), 128'(0));
    repeat (2) @(negedge clk);
    chk({nm, "_queue_drained"}, 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  initial begin
    fork
      mon_loop();
    join_none
    rst_i = 1'b1;
    start_i = 1'b0;
    clear_devs();
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 128'({busy_o, done_o, err_o, dev_count_o, bus.cs_config_o, bus.we_o}), 128'(0));
    chk("rst_adr_sel", 128'({bus.sel_o, bus.adr_o}), 128'(0));
    chk("rst_dat", bus.dat_o, 128'(0));
    rst_i = 1'b0;
    @(negedge clk);

    // Empty bus: four row-0 reads, 3 cycles each, done in cycle 13
    for (int d = 0; d < 4; d++) push_rd(d, 5'd0);
    run_scan("no_dev", 13, 0, 1'b0, 0);

    // Single device at 2 with an unimplemented middle BAR
    set_dev(2, 32'hFFFF0000, 32'h0, 32'hFFFFF000);
    push_rd(0, 5'd0);
    push_rd(1, 5'd0);
    push_present(2, 32'hD0000000, 32'h0, 32'hD0010000, 5'd31);
    push_rd(3, 5'd0);
    run_scan("one_dev", 22, 1, 1'b0, 0);

    // Natural alignment after a 4 KiB BAR, and IRQ wrap 31 -> 1 -> 2
    clear_devs();
    set_dev(0, 32'hFFFFF000, 32'h0, 32'h0);
    set_dev(1, 32'hFFFF0000, 32'h0, 32'h0);
    set_dev(2, 32'hFFFF0000, 32'h0, 32'h0);
    push_present(0, 32'hD0000000, 32'h0, 32'h0, 5'd31);
    push_present(1, 32'hD0010000, 32'h0, 32'h0, 5'd1);
    push_present(2, 32'hD0020000, 32'h0, 32'h0, 5'd2);
    push_rd(3, 5'd0);
    run_scan("align", 40, 3, 1'b0, 0);

    // 256 MiB BAR1 cannot fit after BAR0; BAR2 still placed
    clear_devs();
    set_dev(1, 32'hFFFF0000, 32'hF0000000, 32'hFFFFF000);
    push_rd(0, 5'd0);
    push_present(1, 32'hD0000000, 32'h0, 32'hD0010000, 5'd31);
    push_rd(2, 5'd0);
    push_rd(3, 5'd0);
    run_scan("overflow", 22, 1, 1'b1, 0);

    // Second start while busy must not disturb the scan
    clear_devs();
    for (int d = 0; d < 4; d++) push_rd(d, 5'd0);
    run_scan("restart_ignored", 13, 0, 1'b0, 5);

    // Reset while in SZ_WAIT (cycle 5): outputs clear, no further strobes
    set_dev(0, 32'hFFFFF000, 32'h0, 32'h0);
    push_rd(0, 5'd0);
    push_wr(0, 5'd1, 16'h0FFF, {32'h0, {96{1'b1}}});
    push_rd(0, 5'd1);
    start_i = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_ctrl", 128'({busy_o, done_o, err_o, dev_count_o, bus.cs_config_o, bus.we_o}), 128'(0));
    chk("midrst_adr_sel", 128'({bus.sel_o, bus.adr_o}), 128'(0));
    chk("midrst_dat", bus.dat_o, 128'(0));
    rst_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_more_strobes", 128'(exp_q.size()), 128'(0));
    chk("midrst_idle", 128'(busy_o), 128'(0));
    exp_q.delete();

    // Fresh scan after reset starts again at device 0 and MEM_BASE
    push_present(0, 32'hD0000000, 32'h0, 32'h0, 5'd31);
    push_rd(1, 5'd0);
    push_rd(2, 5'd0);
    push_rd(3, 5'd0);
    run_scan("rescan", 22, 1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
